// File: rtl/block_program_controller_if.sv
// rtl/block_program_controller_if.sv - host command bus into the block program controller
interface block_program_controller_if #(
  parameter int AW = 8
) ();
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_type;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_data;

  modport master (
    output cmd_valid,
    output cmd_type,
    output cmd_addr,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_type,
    input  cmd_addr,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/block_program_controller.sv
// rtl/block_program_controller.sv - double-buffered block program with frame-aligned bank swap
module block_program_controller #(
  parameter int data_width     = 16,
  parameter int n_blocks       = 256,
  parameter int timeout_cycles = 4096,
  localparam int AW            = $clog2(n_blocks)
) (
  input  logic                  clk,
  input  logic                  reset,
  block_program_controller_if.slave cmd,
  input  logic                  frame_start,
  output logic                  bank_sel,
  output logic [AW-1:0]         n_blocks_running,
  output logic                  mem_wr_bank,
  output logic [AW-1:0]         mem_wr_addr,
  output logic [31:0]           mem_wr_data,
  output logic                  mem_we_instr,
  output logic                  mem_we_reg0,
  output logic                  mem_we_reg1,
  output logic                  swap_done,
  output logic                  armed,
  output logic                  err_illegal,
  output logic                  err_timeout
);

  localparam int TW = $clog2(timeout_cycles);
  localparam logic [TW-1:0] TIMER_LAST = TW'(timeout_cycles - 1);
  localparam logic [31:0] DATA_MASK =
    (data_width >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << data_width) - 64'd1);

  localparam logic [2:0] CMD_INSTR  = 3'd0;
  localparam logic [2:0] CMD_REG0   = 3'd1;
  localparam logic [2:0] CMD_REG1   = 3'd2;
  localparam logic [2:0] CMD_COUNT  = 3'd3;
  localparam logic [2:0] CMD_COMMIT = 3'd4;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SWAP  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          accept;
  logic          swap_fire;
  logic          swap_forced;
  logic [TW-1:0] timer;
  logic [AW-1:0] pending_count;

  // Gated by reset so every output reads 0 while reset is held.
  assign cmd.cmd_ready = (state == ST_LOAD) && !reset;
  assign mem_wr_bank   = !bank_sel && !reset;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_LOAD;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    swap_fire   = 1'b0;
    swap_forced = 1'b0;
    case (state)
      ST_LOAD: begin
        if (cmd.cmd_valid) begin
          accept = 1'b1;
          if (cmd.cmd_type == CMD_COMMIT) state_next = ST_ARMED;
        end
      end
      ST_ARMED: begin
        // A real frame boundary wins over the timeout when both land together.
        if (frame_start) begin
          swap_fire  = 1'b1;
          state_next = ST_SWAP;
        end else if (timer == TIMER_LAST) begin
          swap_fire   = 1'b1;
          swap_forced = 1'b1;
          state_next  = ST_SWAP;
        end
      end
      ST_SWAP:  state_next = ST_LOAD;
      default:  state_next = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_sel         <= 1'b0;
      n_blocks_running <= '0;
      mem_wr_addr      <= '0;
      mem_wr_data      <= '0;
      mem_we_instr     <= 1'b0;
      mem_we_reg0      <= 1'b0;
      mem_we_reg1      <= 1'b0;
      swap_done        <= 1'b0;
      armed            <= 1'b0;
      err_illegal      <= 1'b0;
      err_timeout      <= 1'b0;
      pending_count    <= '0;
      timer            <= '0;
    end else begin
      mem_we_instr <= 1'b0;
      mem_we_reg0  <= 1'b0;
      mem_we_reg1  <= 1'b0;
      swap_done    <= 1'b0;

      if (state == ST_ARMED) timer <= timer + TW'(1);

      if (accept) begin
        case (cmd.cmd_type)
          CMD_INSTR: begin
            mem_we_instr <= 1'b1;
            mem_wr_addr  <= cmd.cmd_addr;
            mem_wr_data  <= cmd.cmd_data;
          end
          CMD_REG0: begin
            mem_we_reg0 <= 1'b1;
            mem_wr_addr <= cmd.cmd_addr;
            mem_wr_data <= cmd.cmd_data & DATA_MASK;
          end
          CMD_REG1: begin
            mem_we_reg1 <= 1'b1;
            mem_wr_addr <= cmd.cmd_addr;
            mem_wr_data <= cmd.cmd_data & DATA_MASK;
          end
          CMD_COUNT:  pending_count <= cmd.cmd_data[AW-1:0];
          CMD_COMMIT: begin
            armed <= 1'b1;
            timer <= '0;
          end
          default:    err_illegal <= 1'b1;
        endcase
      end

      if (swap_fire) begin
        bank_sel         <= !bank_sel;
        n_blocks_running <= pending_count;
        swap_done        <= 1'b1;
        armed            <= 1'b0;
        if (swap_forced) err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_block_program_controller.sv
// tb/tb_block_program_controller.sv - directed self-checking bench for block_program_controller
module tb_block_program_controller;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start;
  logic          bank_sel;
  logic [AW-1:0] n_blocks_running;
  logic          mem_wr_bank;
  logic [AW-1:0] mem_wr_addr;
  logic [31:0]   mem_wr_data;
  logic          mem_we_instr;
  logic          mem_we_reg0;
  logic          mem_we_reg1;
  logic          swap_done;
  logic          armed;
  logic          err_illegal;
  logic          err_timeout;

  int tests  = 0;
  int failed = 0;
  int cycles;
  int extra_swaps;

  block_program_controller_if #(.AW(AW)) bif ();

  block_program_controller #(
    .data_width     (16),
    .n_blocks       (256),
    .timeout_cycles (16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd              (bif.slave),
    .frame_start      (frame_start),
    .bank_sel         (bank_sel),
    .n_blocks_running (n_blocks_running),
    .mem_wr_bank      (mem_wr_bank),
    .mem_wr_addr      (mem_wr_addr),
    .mem_wr_data      (mem_wr_data),
    .mem_we_instr     (mem_we_instr),
    .mem_we_reg0      (mem_we_reg0),
    .mem_we_reg1      (mem_we_reg1),
    .swap_done        (swap_done),
    .armed            (armed),
    .err_illegal      (err_illegal),
    .err_timeout      (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] t, input logic [AW-1:0] a, input logic [31:0] d);
    bif.cmd_valid = 1'b1;
    bif.cmd_type  = t;
    bif.cmd_addr  = a;
    bif.cmd_data  = d;
  endtask

  task automatic idle();
    bif.cmd_valid = 1'b0;
    bif.cmd_type  = 3'd0;
    bif.cmd_addr  = '0;
    bif.cmd_data  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    frame_start = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_cmd_ready", bif.cmd_ready, 0);
    chk("rst_bank_sel", bank_sel, 0);
    chk("rst_n_blocks", n_blocks_running, 0);
    chk("rst_wr_bank", mem_wr_bank, 0);
    chk("rst_armed", armed, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", bif.cmd_ready, 1);
    chk("post_rst_wr_bank", mem_wr_bank, 1);

    // instr write lands in shadow bank 1 one cycle after accept
    send(3'd0, 8'd5, 32'hDEADBEEF);
    tick();
    idle();
    chk("instr_we", mem_we_instr, 1);
    chk("instr_addr", mem_wr_addr, 5);
    chk("instr_data", mem_wr_data, 32'hDEADBEEF);
    chk("instr_bank", mem_wr_bank, 1);
    chk("instr_bank_sel", bank_sel, 0);
    tick();
    chk("instr_we_one_cycle", mem_we_instr, 0);

    // count 3, commit, frame_start 10 cycles after armed
    send(3'd3, 8'd0, 32'h0000_0103);
    tick();
    chk("count_no_strobe", {mem_we_instr, mem_we_reg0, mem_we_reg1}, 0);
    send(3'd4, 8'd0, 32'd0);
    tick();
    idle();
    chk("commit_armed", armed, 1);
    chk("commit_ready", bif.cmd_ready, 0);
    for (int i = 0; i < 9; i++) tick();
    chk("armed_no_swap_yet", swap_done, 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("frame_swap_done", swap_done, 1);
    chk("frame_bank_sel", bank_sel, 1);
    chk("frame_n_blocks", n_blocks_running, 3);
    chk("frame_armed_clr", armed, 0);
    chk("frame_wr_bank", mem_wr_bank, 0);
    chk("frame_no_timeout", err_timeout, 0);
    chk("swap_cycle_ready", bif.cmd_ready, 0);
    tick();
    chk("swap_done_pulse", swap_done, 0);
    chk("after_swap_ready", bif.cmd_ready, 1);

    // frame_start in LOAD is ignored
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("load_frame_ignored", swap_done, 0);
    chk("load_frame_bank", bank_sel, 1);

    // count 0, commit, frame_start on the same cycle as the timeout
    send(3'd3, 8'd0, 32'd0);
    tick();
    send(3'd4, 8'd0, 32'd0);
    tick();
    idle();
    extra_swaps = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (swap_done) extra_swaps++;
    end
    chk("coinc_no_early_swap", extra_swaps, 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("coinc_swap_done", swap_done, 1);
    chk("coinc_no_timeout", err_timeout, 0);
    chk("coinc_bank_sel", bank_sel, 0);
    chk("coinc_zero_count", n_blocks_running, 0);
    tick();

    // forced swap 16 cycles after armed
    send(3'd3, 8'd0, 32'd7);
    tick();
    send(3'd4, 8'd0, 32'd0);
    tick();
    idle();
    chk("to_armed", armed, 1);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!swap_done && cycles < 40);
    chk("to_latency", cycles, 16);
    chk("to_err_timeout", err_timeout, 1);
    chk("to_bank_sel", bank_sel, 1);
    chk("to_n_blocks", n_blocks_running, 7);
    chk("to_armed_clr", armed, 0);
    tick();

    // illegal command type
    send(3'd6, 8'd3, 32'h55);
    tick();
    idle();
    chk("ill_no_strobe", {mem_we_instr, mem_we_reg0, mem_we_reg1}, 0);
    chk("ill_err", err_illegal, 1);
    chk("ill_ready", bif.cmd_ready, 1);
    tick();
    tick();
    chk("ill_sticky", err_illegal, 1);

    // three back-to-back reg0 writes
    send(3'd1, 8'd0, 32'h1234_0001);
    tick();
    send(3'd1, 8'd1, 32'hABCD_0002);
    chk("r0a_we", mem_we_reg0, 1);
    chk("r0a_addr", mem_wr_addr, 0);
    chk("r0a_data", mem_wr_data, 32'h0001);
    tick();
    send(3'd1, 8'd2, 32'hFFFF_8003);
    chk("r0b_we", mem_we_reg0, 1);
    chk("r0b_addr", mem_wr_addr, 1);
    chk("r0b_data", mem_wr_data, 32'h0002);
    tick();
    idle();
    chk("r0c_we", mem_we_reg0, 1);
    chk("r0c_addr", mem_wr_addr, 2);
    chk("r0c_data", mem_wr_data, 32'h8003);
    chk("r0c_no_instr", mem_we_instr, 0);
    tick();
    chk("r0_end", mem_we_reg0, 0);

    // reg1 write, zero-extended
    send(3'd2, 8'd9, 32'hFFFF_FFFF);
    tick();
    idle();
    chk("r1_we", mem_we_reg1, 1);
    chk("r1_addr", mem_wr_addr, 9);
    chk("r1_data", mem_wr_data, 32'h0000_FFFF);
    tick();

    // reset while armed aborts the commit
    send(3'd3, 8'd0, 32'd9);
    tick();
    send(3'd4, 8'd0, 32'd0);
    tick();
    idle();
    chk("rstarm_armed", armed, 1);
    reset = 1'b1;
    tick();
    chk("rstarm_outputs",
        {bif.cmd_ready, bank_sel, mem_wr_bank, mem_we_instr, mem_we_reg0, mem_we_reg1,
         swap_done, armed, err_illegal, err_timeout}, 0);
    chk("rstarm_n_blocks", n_blocks_running, 0);
    chk("rstarm_addr", mem_wr_addr, 0);
    chk("rstarm_data", mem_wr_data, 0);
    reset = 1'b0;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("rstarm_no_swap", swap_done, 0);
    chk("rstarm_bank_sel", bank_sel, 0);
    chk("rstarm_ready", bif.cmd_ready, 1);
    tick();
    chk("rstarm_n_blocks_after", n_blocks_running, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
